reset_sequencer: RTL

//  Staged reset controller between the clock wizard and the design's reset domains (e.g. camera, detector, VGA).

---
 rtl/reset_sequencer_pkg.sv | 19 +
 rtl/reset_sequencer_sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default timings,
// and a small helper for sizing the shared delay/watchdog counter.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_DELAY    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_DONE     = 2'd3
   } seq_state_e;

   localparam int DEF_DELAY_CYCLES = 10;
   localparam int DEF_WDT_CYCLES   = 1_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (used for locked).
module reset_sequencer_sync_2ff (
   input  logic pclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged release of active-high domain resets after clock lock, in index order.
// Define RST_SEQ_WDT_EN to build the ack watchdog (sticky err, automatic retry).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HOLD     | all domain resets asserted, waiting for synchronised lock
// DELAY    | counting down before releasing rst_out[cur_stage]
// WAIT_ACK | stage released, waiting for stage_ack[cur_stage]
// DONE     | every domain released
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int                  N_STAGES     = 3,
   parameter int                  DELAY_CYCLES = DEF_DELAY_CYCLES,
   parameter logic [N_STAGES-1:0] ACK_MASK     = 3'b010,
   parameter int                  WDT_CYCLES   = DEF_WDT_CYCLES,
   parameter int                  STAGE_W      = $clog2(N_STAGES)
) (
   input  logic                pclk,
   input  logic                rst_n,
   input  logic                locked,
   input  logic                sw_rst_req,
   input  logic [N_STAGES-1:0] stage_ack,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_busy,
   output logic                seq_done,
   output logic [STAGE_W-1:0]  cur_stage,
   output logic                err
);

`ifdef RST_SEQ_WDT_EN
   localparam int CNT_TOP = max_int(DELAY_CYCLES - 1, WDT_CYCLES - 1);
`else
   localparam int CNT_TOP = DELAY_CYCLES - 1;
`endif
   localparam int CNT_W = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);

   localparam logic [CNT_W-1:0]   CNT_DELAY  = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);

   seq_state_e          state_q, state_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic [STAGE_W-1:0]  stage_q, stage_nxt;
   logic [N_STAGES-1:0] rst_q, rst_nxt;
   logic                busy_q, busy_nxt;
   logic                done_q, done_nxt;
   logic                locked_s;
   logic                step;
   logic                abort;

   reset_sequencer_sync_2ff u_sync_locked (
      .pclk  (pclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign abort = (state_q != ST_HOLD) && (!locked_s || sw_rst_req);

`ifdef RST_SEQ_WDT_EN
   localparam logic [CNT_W-1:0] CNT_WDT = CNT_W'(WDT_CYCLES - 1);
   logic err_q, err_nxt;
   logic timeout;

   assign timeout = (state_q == ST_WAIT_ACK) && !stage_ack[stage_q] && (cnt_q == '0);

   always_comb begin
      err_nxt = err_q;
      if (timeout)
         err_nxt = 1'b1;
      // A software request clears err even when a same-cycle lock loss wins.
      if ((state_q != ST_HOLD) && sw_rst_req)
         err_nxt = 1'b0;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_nxt;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      stage_nxt = stage_q;
      rst_nxt   = rst_q;
      step      = 1'b0;
      unique case (state_q)
         ST_HOLD: begin
            if (locked_s) begin
               state_nxt = ST_DELAY;
               cnt_nxt   = CNT_DELAY;
            end
         end
         ST_DELAY: begin
            if (cnt_q == '0) begin
               rst_nxt = rst_q & ~(N_STAGES'(1) << stage_q);
               if (ACK_MASK[stage_q]) begin
                  state_nxt = ST_WAIT_ACK;
`ifdef RST_SEQ_WDT_EN
                  cnt_nxt   = CNT_WDT;
`endif
               end else begin
                  step = 1'b1;
               end
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_ACK: begin
            if (stage_ack[stage_q]) begin
               step = 1'b1;
            end
`ifdef RST_SEQ_WDT_EN
            else if (timeout) begin
               state_nxt = ST_HOLD;
               rst_nxt   = '1;
               stage_nxt = '0;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
`endif
         end
         ST_DONE: begin
         end
      endcase

      if (step) begin
         if (stage_q == STAGE_LAST) begin
            state_nxt = ST_DONE;
         end else begin
            state_nxt = ST_DELAY;
            stage_nxt = stage_q + STAGE_W'(1);
            cnt_nxt   = CNT_DELAY;
         end
      end

      // Lock loss / software restart overrides any release or ack this cycle.
      if (abort) begin
         state_nxt = ST_HOLD;
         rst_nxt   = '1;
         stage_nxt = '0;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      busy_nxt = (state_nxt == ST_DELAY) || (state_nxt == ST_WAIT_ACK);
      done_nxt = (state_nxt == ST_DONE);
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         stage_q <= '0;
         rst_q   <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         stage_q <= stage_nxt;
         rst_q   <= rst_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   assign rst_out   = rst_q;
   assign seq_busy  = busy_q;
   assign seq_done  = done_q;
   assign cur_stage = stage_q;

endmodule
